// File: rtl/leaf_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_port_arbiter
//  Description : Bidirectional leaf-port stream concentrator.
//                Merge path : NUM_PORTS ingress streams -> per-port ingress
//                             FIFO -> round-robin grant -> registered merged
//                             stream (mrg_*) tagged with its source port.
//                Split path : tagged stream from the core (spl_*) -> per-port
//                             first-word-fall-through egress FIFO -> out_*.
//                             Words tagged with a non-existent port are
//                             accepted, discarded and counted in drop_cnt.
//  Ports       : clk, resetn (async, active-low)
//                in_data/in_vld/in_ack      ingress streams (slice i = port i)
//                mrg_data/mrg_port/mrg_vld/mrg_ack   merged stream to core
//                spl_data/spl_port/spl_vld/spl_ack   tagged stream from core
//                out_data/out_vld/out_ack   egress streams (slice i = port i)
//                drop_cnt                   saturating count of dropped words
//  Revision    : 1.0 - initial release
// ============================================================================
module leaf_port_arbiter #(
    parameter int NUM_PORTS    = 5,
    parameter int PAYLOAD_BITS = 32,
    parameter int PORT_BITS    = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] in_data,
    input  logic [NUM_PORTS-1:0]              in_vld,
    output logic [NUM_PORTS-1:0]              in_ack,
    output logic [PAYLOAD_BITS-1:0]           mrg_data,
    output logic [PORT_BITS-1:0]              mrg_port,
    output logic                              mrg_vld,
    input  logic                              mrg_ack,
    input  logic [PAYLOAD_BITS-1:0]           spl_data,
    input  logic [PORT_BITS-1:0]              spl_port,
    input  logic                              spl_vld,
    output logic                              spl_ack,
    output logic [NUM_PORTS*PAYLOAD_BITS-1:0] out_data,
    output logic [NUM_PORTS-1:0]              out_vld,
    input  logic [NUM_PORTS-1:0]              out_ack,
    output logic [15:0]                       drop_cnt
);

    localparam int                   c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                   c_CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int                   c_TAG_SPAN = 1 << PORT_BITS;
    localparam logic [c_CNT_W-1:0]   c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [PORT_BITS-1:0] c_NUM_TAG  = PORT_BITS'(NUM_PORTS);
    localparam logic [PORT_BITS-1:0] c_LAST_TAG = PORT_BITS'(NUM_PORTS - 1);
    localparam logic [PORT_BITS:0]   c_NUM_EXT  = (PORT_BITS + 1)'(NUM_PORTS);

    // ------------------------------------------------------------------
    // Merge-path signals
    // ------------------------------------------------------------------
    logic [PAYLOAD_BITS-1:0] w_ing_head [NUM_PORTS];
    logic [NUM_PORTS-1:0]    w_ing_ne;
    logic [NUM_PORTS-1:0]    w_ing_pop;
    logic [c_TAG_SPAN-1:0]   w_ing_ne_pad;
    logic [PORT_BITS:0]      w_idx;
    logic                    w_grant_vld;
    logic [PORT_BITS-1:0]    w_grant;
    logic [PAYLOAD_BITS-1:0] w_grant_data;
    logic                    w_load;

    logic [PAYLOAD_BITS-1:0] r_mrg_data;
    logic [PORT_BITS-1:0]    r_mrg_port;
    logic                    r_mrg_vld;
    logic [PORT_BITS-1:0]    r_rr_ptr;     // first port searched next cycle

    // ------------------------------------------------------------------
    // Split-path signals
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0]    w_eg_full;
    logic [c_TAG_SPAN-1:0]   w_eg_full_pad;
    logic                    w_port_ok;
    logic [15:0]             r_drop_cnt;

    // ------------------------------------------------------------------
    // Ingress FIFOs. in_ack comes from the registered count only, so a full
    // FIFO refuses a word even in the cycle its head is being popped.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ingress
        logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0]      r_wr;
        logic [c_PTR_W-1:0]      r_rd;
        logic [c_CNT_W-1:0]      r_cnt;
        logic                    w_push;
        logic                    w_pop;

        assign in_ack[i]     = (r_cnt != c_FULL);
        assign w_ing_ne[i]   = (r_cnt != '0);
        assign w_ing_head[i] = r_mem[r_rd];
        assign w_push        = in_vld[i] & in_ack[i];
        assign w_pop         = w_ing_pop[i];

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr] <= in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + c_PTR_W'(1);
                if (w_pop)  r_rd <= r_rd + c_PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // Padded to the full tag space so a PORT_BITS-wide index is always legal.
    assign w_ing_ne_pad = {{(c_TAG_SPAN - NUM_PORTS){1'b0}}, w_ing_ne};

    // ------------------------------------------------------------------
    // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_PORTS.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (PORT_BITS + 1)'(k);
            if (w_idx >= c_NUM_EXT) begin
                w_idx = w_idx - c_NUM_EXT;
            end
            if (!w_grant_vld && w_ing_ne_pad[w_idx[PORT_BITS-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx[PORT_BITS-1:0];
            end
        end
    end

    // The output register reloads whenever it is empty or being drained.
    assign w_load = w_grant_vld & (~r_mrg_vld | mrg_ack);

    always_comb begin
        w_grant_data = '0;
        w_ing_pop    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_grant == PORT_BITS'(p)) begin
                w_grant_data = w_ing_head[p];
                w_ing_pop[p] = w_load;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mrg_vld  <= 1'b0;
            r_mrg_data <= '0;
            r_mrg_port <= '0;
            r_rr_ptr   <= '0;
        end else if (w_load) begin
            r_mrg_vld  <= 1'b1;
            r_mrg_data <= w_grant_data;
            r_mrg_port <= w_grant;
            r_rr_ptr   <= (w_grant == c_LAST_TAG) ? '0 : w_grant + PORT_BITS'(1);
        end else if (mrg_ack) begin
            r_mrg_vld  <= 1'b0;
        end
    end

    assign mrg_vld  = r_mrg_vld;
    assign mrg_data = r_mrg_data;
    assign mrg_port = r_mrg_port;

    // ------------------------------------------------------------------
    // Split path. Unknown ports are always acked so a bad tag can never
    // stall the core; those words are simply counted and discarded.
    // ------------------------------------------------------------------
    assign w_port_ok     = (spl_port < c_NUM_TAG);
    assign w_eg_full_pad = {{(c_TAG_SPAN - NUM_PORTS){1'b0}}, w_eg_full};
    assign spl_ack       = ~w_port_ok | ~w_eg_full_pad[spl_port];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_egress
        logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0]      r_wr;
        logic [c_PTR_W-1:0]      r_rd;
        logic [c_CNT_W-1:0]      r_cnt;
        logic                    w_push;
        logic                    w_pop;

        assign w_eg_full[i] = (r_cnt == c_FULL);
        assign out_vld[i]   = (r_cnt != '0);
        assign out_data[i*PAYLOAD_BITS +: PAYLOAD_BITS] = r_mem[r_rd];
        assign w_push = spl_vld & w_port_ok & ~w_eg_full[i]
                      & (spl_port == PORT_BITS'(i));
        assign w_pop  = out_vld[i] & out_ack[i];

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr] <= spl_data;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + c_PTR_W'(1);
                if (w_pop)  r_rd <= r_rd + c_PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop_cnt <= '0;
        end else if (spl_vld && !w_port_ok && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_leaf_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_leaf_port_arbiter
//  Description : Self-checking bench for leaf_port_arbiter (default params).
//                Ingress and split words are queued as they are accepted and
//                matched per port when they leave the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_port_arbiter;

    localparam int NP = 5;
    localparam int PB = 32;
    localparam int TB = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic [NP*PB-1:0] in_data;
    logic [NP-1:0]    in_vld;
    logic [NP-1:0]    in_ack;
    logic [PB-1:0]    mrg_data;
    logic [TB-1:0]    mrg_port;
    logic             mrg_vld;
    logic             mrg_ack;
    logic [PB-1:0]    spl_data;
    logic [TB-1:0]    spl_port;
    logic             spl_vld;
    logic             spl_ack;
    logic [NP*PB-1:0] out_data;
    logic [NP-1:0]    out_vld;
    logic [NP-1:0]    out_ack;
    logic [15:0]      drop_cnt;

    leaf_port_arbiter #(
        .NUM_PORTS   (NP),
        .PAYLOAD_BITS(PB),
        .PORT_BITS   (TB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .in_data (in_data),
        .in_vld  (in_vld),
        .in_ack  (in_ack),
        .mrg_data(mrg_data),
        .mrg_port(mrg_port),
        .mrg_vld (mrg_vld),
        .mrg_ack (mrg_ack),
        .spl_data(spl_data),
        .spl_port(spl_port),
        .spl_vld (spl_vld),
        .spl_ack (spl_ack),
        .out_data(out_data),
        .out_vld (out_vld),
        .out_ack (out_ack),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TB-1:0] port;
        logic [PB-1:0] data;
    } item_t;

    typedef struct {
        logic          vld;
        logic [TB-1:0] port;
        logic [PB-1:0] data;
        logic          ack;
        logic [NP-1:0] ovld;
        logic [15:0]   drop;
    } spl_vec_t;

    item_t in_q[$];
    item_t eg_q[$];
    int    mrg_log_port[$];
    int    mrg_log_cyc[$];
    int    mrg_seen = 0;
    int    cyc      = 0;
    int    errors   = 0;
    int    checks   = 0;

    spl_vec_t vecs [12];
    int       fair_exp [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        in_q.delete();
        eg_q.delete();
        mrg_log_port.delete();
        mrg_log_cyc.delete();
        mrg_seen = 0;
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        in_vld  = '0;
        spl_vld = 1'b0;
        mrg_ack = 1'b0;
        out_ack = '0;
        clear_model();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Handshakes complete at the next rising edge; inputs only change just
    // after a rising edge, so the falling edge sees the values that count.
    always @(negedge clk) begin : monitor
        int idx;
        if (resetn) begin
            if (mrg_vld && mrg_ack) begin
                idx = -1;
                foreach (in_q[j]) if (idx < 0 && in_q[j].port == mrg_port) idx = j;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL merged_word: got port %0d data 0x%h, required no word", mrg_port, mrg_data);
                end else begin
                    if (in_q[idx].data !== mrg_data) begin
                        errors++;
                        $display("FAIL merged_word: port %0d got 0x%h, required 0x%h", mrg_port, mrg_data, in_q[idx].data);
                    end
                    in_q.delete(idx);
                end
                mrg_log_port.push_back(int'(mrg_port));
                mrg_log_cyc.push_back(cyc);
                mrg_seen++;
            end
            for (int i = 0; i < NP; i++) begin
                if (out_vld[i] && out_ack[i]) begin
                    idx = -1;
                    foreach (eg_q[j]) if (idx < 0 && int'(eg_q[j].port) == i) idx = j;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL egress_word: port %0d got 0x%h, required no word", i, out_data[i*PB +: PB]);
                    end else begin
                        if (eg_q[idx].data !== out_data[i*PB +: PB]) begin
                            errors++;
                            $display("FAIL egress_word: port %0d got 0x%h, required 0x%h", i, out_data[i*PB +: PB], eg_q[idx].data);
                        end
                        eg_q.delete(idx);
                    end
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (in_vld[i] && in_ack[i]) in_q.push_back('{port: TB'(i), data: in_data[i*PB +: PB]});
            end
            if (spl_vld && spl_ack && int'(spl_port) < NP) begin
                eg_q.push_back('{port: spl_port, data: spl_data});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int guard;

        //              vld   port   data           ack   out_vld   drop
        vecs[0]  = '{1'b1, 4'd1,  32'h1111_0001, 1'b1, 5'b00010, 16'd0};
        vecs[1]  = '{1'b1, 4'd9,  32'h9999_0009, 1'b1, 5'b00010, 16'd1};
        vecs[2]  = '{1'b1, 4'd15, 32'hFFFF_000F, 1'b1, 5'b00010, 16'd2};
        vecs[3]  = '{1'b1, 4'd0,  32'h0000_0A00, 1'b1, 5'b00011, 16'd2};
        vecs[4]  = '{1'b1, 4'd0,  32'h0000_0A01, 1'b1, 5'b00011, 16'd2};
        vecs[5]  = '{1'b1, 4'd0,  32'h0000_0A02, 1'b1, 5'b00011, 16'd2};
        vecs[6]  = '{1'b1, 4'd0,  32'h0000_0A03, 1'b1, 5'b00011, 16'd2};
        vecs[7]  = '{1'b1, 4'd0,  32'h0000_0A04, 1'b0, 5'b00011, 16'd2};
        vecs[8]  = '{1'b1, 4'd2,  32'h2222_0002, 1'b1, 5'b00111, 16'd2};
        vecs[9]  = '{1'b1, 4'd5,  32'h5555_0005, 1'b1, 5'b00111, 16'd3};
        vecs[10] = '{1'b0, 4'd9,  32'h0BAD_0BAD, 1'b1, 5'b00111, 16'd3};
        vecs[11] = '{1'b1, 4'd4,  32'h4444_0004, 1'b1, 5'b10111, 16'd3};
        fair_exp = '{0, 1, 4};

        in_data  = '0;
        in_vld   = '0;
        mrg_ack  = 1'b0;
        spl_data = '0;
        spl_port = '0;
        spl_vld  = 1'b0;
        out_ack  = '0;
        resetn   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        chk("rst_in_ack",   64'(in_ack),   64'h1F);
        chk("rst_spl_ack",  64'(spl_ack),  64'h1);
        chk("rst_mrg_vld",  64'(mrg_vld),  64'h0);
        chk("rst_mrg_data", 64'(mrg_data), 64'h0);
        chk("rst_mrg_port", 64'(mrg_port), 64'h0);
        chk("rst_out_vld",  64'(out_vld),  64'h0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
        resetn = 1'b1;
        tick();

        // ---------------- single word, 2-cycle latency ----------------
        mrg_ack = 1'b1;
        in_data[2*PB +: PB] = 32'hDEADBEEF;
        in_vld = 5'b00100;
        tick();                                   // accepted at this edge
        in_vld = '0;
        chk("single_lat_k",   64'(mrg_vld), 64'h0);
        tick();
        chk("single_vld",     64'(mrg_vld),  64'h1);
        chk("single_data",    64'(mrg_data), 64'hDEADBEEF);
        chk("single_port",    64'(mrg_port), 64'h2);
        tick();
        chk("single_one_cyc", 64'(mrg_vld),  64'h0);

        // ---------------- round-robin fairness ----------------
        do_reset();
        for (int w = 0; w < 3; w++) begin
            in_data[0*PB +: PB] = 32'h0000_0000 + 32'(w);
            in_data[1*PB +: PB] = 32'h1000_0000 + 32'(w);
            in_data[4*PB +: PB] = 32'h4000_0000 + 32'(w);
            in_vld = 5'b10011;
            tick();
        end
        in_vld  = '0;
        mrg_ack = 1'b1;
        for (int n = 0; n < 12; n++) tick();
        chk("fair_count", 64'(mrg_log_port.size()), 64'd9);
        for (int n = 0; n < 9 && n < mrg_log_port.size(); n++) begin
            chk($sformatf("fair_port[%0d]", n), 64'(mrg_log_port[n]), 64'(fair_exp[n % 3]));
            if (n > 0) chk($sformatf("fair_nobubble[%0d]", n), 64'(mrg_log_cyc[n] - mrg_log_cyc[n-1]), 64'd1);
        end

        // ---------------- merge backpressure ----------------
        do_reset();
        for (int w = 0; w < 5; w++) begin
            in_data[3*PB +: PB] = 32'h3300_0000 + 32'(w);
            in_vld = 5'b01000;
            guard  = 0;
            while (!in_ack[3] && guard < 10) begin
                tick();
                guard++;
            end
            chk($sformatf("bp_accept_wait[%0d]", w), 64'(in_ack[3]), 64'h1);
            tick();
        end
        in_data[3*PB +: PB] = 32'h3300_0005;      // sixth word, held offered
        chk("bp_in_ack_full", 64'(in_ack[3]), 64'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("bp_hold_ack",  64'(in_ack[3]), 64'h0);
            chk("bp_hold_vld",  64'(mrg_vld),   64'h1);
            chk("bp_hold_port", 64'(mrg_port),  64'h3);
            chk("bp_hold_data", 64'(mrg_data),  64'h3300_0000);
        end
        mrg_ack = 1'b1;                           // pop while full: no accept
        tick();
        chk("bp_ack_after_pop", 64'(in_ack[3]), 64'h1);
        tick();
        in_vld = '0;
        for (int n = 0; n < 8; n++) tick();
        chk("bp_drained", 64'(mrg_seen), 64'd6);
        chk("bp_idle",    64'(mrg_vld),  64'h0);

        // ---------------- split path vectors ----------------
        do_reset();
        for (int v = 0; v < 12; v++) begin
            spl_vld  = vecs[v].vld;
            spl_port = vecs[v].port;
            spl_data = vecs[v].data;
            #1;
            chk($sformatf("spl_ack[%0d]", v), 64'(spl_ack), 64'(vecs[v].ack));
            tick();
            chk($sformatf("spl_out_vld[%0d]", v), 64'(out_vld),  64'(vecs[v].ovld));
            chk($sformatf("spl_drop[%0d]", v),    64'(drop_cnt), 64'(vecs[v].drop));
        end
        spl_vld = 1'b0;
        out_ack = 5'h1F;
        for (int n = 0; n < 8; n++) tick();
        chk("spl_drained_vld", 64'(out_vld), 64'h0);

        // ---------------- reset mid-stream ----------------
        do_reset();
        for (int w = 0; w < 3; w++) begin
            in_data[1*PB +: PB] = 32'h1100_0000 + 32'(w);
            in_vld   = 5'b00010;
            spl_vld  = (w < 2);
            spl_port = (w == 0) ? 4'd3 : 4'd9;
            spl_data = 32'h3333_0003;
            tick();
        end
        in_vld  = '0;
        spl_vld = 1'b0;
        tick();
        chk("mid_pre_mrg_vld", 64'(mrg_vld),  64'h1);
        chk("mid_pre_out_vld", 64'(out_vld),  64'h08);
        chk("mid_pre_drop",    64'(drop_cnt), 64'h1);
        resetn = 1'b0;
        clear_model();
        #1;
        chk("mid_rst_mrg_vld", 64'(mrg_vld),  64'h0);
        chk("mid_rst_out_vld", 64'(out_vld),  64'h0);
        chk("mid_rst_drop",    64'(drop_cnt), 64'h0);
        chk("mid_rst_in_ack",  64'(in_ack),   64'h1F);
        chk("mid_rst_spl_ack", 64'(spl_ack),  64'h1);
        tick();
        resetn  = 1'b1;
        mrg_ack = 1'b1;
        out_ack = 5'h1F;
        in_data[4*PB +: PB] = 32'hA5A5_0004;
        in_vld = 5'b10000;
        tick();
        in_vld = '0;
        for (int n = 0; n < 5; n++) tick();
        chk("mid_post_count", 64'(mrg_seen), 64'd1);
        if (mrg_log_port.size() > 0) chk("mid_post_first_port", 64'(mrg_log_port[0]), 64'd4);
        chk("mid_post_out_vld", 64'(out_vld), 64'h0);

        // Every accepted word must have come out again.
        chk("in_q_empty", 64'(in_q.size()), 64'd0);
        chk("eg_q_empty", 64'(eg_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/leaf_port_arbiter.md
LEAF_PORT_ARBITER -- requirements
Module: leaf_port_arbiter

Interface
REQ-001 SHALL take parameter NUM_PORTS, default 5: number of leaf-interface stream ports, legal range 2..15.
REQ-002 SHALL take parameter PAYLOAD_BITS, default 32: stream word width.
REQ-003 SHALL take parameter PORT_BITS, default 4: port-tag width; requires 2^PORT_BITS > NUM_PORTS.
REQ-004 SHALL take parameter FIFO_DEPTH, default 4: entries per ingress/egress FIFO, power of two, at least 2.
REQ-005 SHALL have clk  input  1: single clock; all logic on rising edge.
REQ-006 SHALL have resetn  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have in_data  input  NUM_PORTS*PAYLOAD_BITS: ingress words; port i occupies slice i.
REQ-008 SHALL have in_vld  input  NUM_PORTS: ingress valid per port.
REQ-009 SHALL have in_ack  output  NUM_PORTS: ingress ready per port.
REQ-010 SHALL have mrg_data  output  PAYLOAD_BITS: merged word to the core.
REQ-011 SHALL have mrg_port  output  PORT_BITS: source-port tag of mrg_data.
REQ-012 SHALL have mrg_vld  output  1 and mrg_ack  input  1: merged-stream handshake.
REQ-013 SHALL have spl_data  input  PAYLOAD_BITS, spl_port  input  PORT_BITS, spl_vld  input  1: tagged word from the core.
REQ-014 SHALL have spl_ack  output  1: split-stream ready.
REQ-015 SHALL have out_data  output  NUM_PORTS*PAYLOAD_BITS, out_vld  output  NUM_PORTS, out_ack  input  NUM_PORTS: egress streams per port.
REQ-016 SHALL have drop_cnt  output  16: count of words dropped for an out-of-range spl_port.

Function
REQ-017 SHALL treat a transfer as complete on any rising edge where the matching vld and ack are both high; a sender holds data stable while vld is high and ack is low.
REQ-018 SHALL give each port one ingress FIFO of FIFO_DEPTH entries, with in_ack[i] = ingress FIFO i not full.
REQ-019 SHALL decide in_ack from registered occupancy only, so a full FIFO does not accept a word in the same cycle it is popped.
REQ-020 SHALL select a grant by round-robin among non-empty ingress FIFOs, searching from (last granted port + 1) mod NUM_PORTS.
REQ-021 SHALL drive mrg_data, mrg_port and mrg_vld from an output register that loads the granted head word and its port index when the register is empty or being acked that cycle, popping that FIFO in the same edge.
REQ-022 SHALL hold mrg_* stable while mrg_vld=1 and mrg_ack=0.
REQ-023 SHALL sustain one merged word per cycle while mrg_ack is held high.
REQ-024 SHALL give 2-cycle latency: a word accepted into an empty system at edge k drives mrg_vld high after edge k+1.
REQ-025 SHALL preserve order within each port; no ordering guarantee across ports beyond round-robin fairness.
REQ-026 SHALL give each port one first-word-fall-through egress FIFO of FIFO_DEPTH entries, with out_vld[i] = egress FIFO i not empty and out_data slice i = head word.
REQ-027 SHALL drive spl_ack = 1 when spl_port >= NUM_PORTS, otherwise spl_ack = egress FIFO[spl_port] not full (registered occupancy).
REQ-028 SHALL accept an out-of-range spl_port word, discard it, and increment drop_cnt by 1, saturating at 0xFFFF.
REQ-029 SHALL give 1-cycle split latency: a word accepted at edge k drives out_vld high after edge k.
REQ-030 SHALL allow simultaneous push and pop on a non-full, non-empty FIFO in one cycle, with occupancy unchanged.
REQ-031 SHALL handle pointer wrap-around modulo FIFO_DEPTH, using an occupancy counter of clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-032 SHALL, while resetn=0, asynchronously clear all FIFO pointers and occupancy counts.
REQ-033 SHALL, while resetn=0, clear mrg_vld, mrg_data, mrg_port, out_vld and drop_cnt to 0, and clear the round-robin pointer so port 0 has first priority.
REQ-034 SHALL, while resetn=0, drive in_ack to all ones (all FIFOs empty) and spl_ack to 1.
REQ-035 SHALL, on reset asserted mid-operation, discard all buffered words without producing partial handshakes; the first transfer after release is the first new word.

Verification
REQ-036 SHALL cover single word: port 2 sends 0xDEADBEEF with mrg_ack=1 -> after 2 cycles mrg_data=0xDEADBEEF, mrg_port=2, mrg_vld high for 1 cycle.
REQ-037 SHALL cover fairness: ports 0,1,4 each hold 3 words with mrg_ack=1 -> mrg_port sequence 0,1,4,0,1,4,0,1,4, no bubbles.
REQ-038 SHALL cover backpressure: mrg_ack=0, port 3 sends 5 words, FIFO_DEPTH=4 -> in_ack[3] low after 5 accepts (4 in FIFO plus 1 in output register), mrg_* stable; releasing mrg_ack drains all 5 in order.
REQ-039 SHALL cover the split path: spl_port=1 then spl_port=9 (NUM_PORTS=5) -> out_vld[1] high with data, spl_ack=1 for port 9, drop_cnt=1, no out_vld change.
REQ-040 SHALL cover egress full: out_ack[0]=0, 4 words to port 0 -> spl_ack low for spl_port=0 while spl_port=2 is still accepted.
REQ-041 SHALL cover reset mid-stream: resetn low with 3 words buffered -> all vld low and drop_cnt=0 immediately; after release the next input emerges first.
